// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and RAM-side bus of the load/store port.
// The slave modport is the LSU; master is the core plus data RAM around it.
interface lsu_mem_port_if #(
    parameter int N = 20
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [63:0]   req_addr;
    logic [63:0]   req_wdata;
    logic          resp_valid;
    logic [63:0]   resp_rdata;
    logic          resp_err;
    logic          mem_we;
    logic [N-1:0]  mem_adr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_adr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_adr, mem_din
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Byte-addressed B/H/W/D load/store initiator for a 32-bit word-addressed RAM:
// read-modify-write for sub-word stores, two beats for doublewords.
module lsu_mem_port #(
    parameter int N = 20
) (
    input  logic            clk,
    input  logic            rst,
    lsu_mem_port_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, MERGE, RESP} state_t;

    state_t         state_reg, state_next;
    logic           we_reg;
    logic [1:0]     size_reg;
    logic           uns_reg;
    logic [1:0]     lane_reg;
    logic [N-1:0]   w0_reg;
    logic [63:0]    wdata_reg;
    logic [31:0]    old_reg;
    logic [63:0]    resp_rdata_reg, rdata_next;
    logic           resp_err_reg, err_next;

    logic           accept;
    logic           misaligned;
    logic [N-1:0]   w1;
    logic [3:0]     lane_en;
    logic [31:0]    merged;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic           mem_we_next;
    logic [N-1:0]   mem_adr_next;
    logic [31:0]    mem_din_next;
    logic           unused_addr;

    assign unused_addr = &{1'b0, bus.req_addr[63:N+2]};

    assign bus.req_ready  = (state_reg == IDLE) && !rst;
    assign accept         = bus.req_valid && bus.req_ready;
    assign misaligned     = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                            ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0)) ||
                            ((bus.req_size == 2'd3) && (bus.req_addr[2:0] != 3'd0));
    assign w1             = w0_reg + {{(N-1){1'b0}}, 1'b1};

    // Lane replacement for sub-word stores: bytes take wdata[7:0], halves take wdata[15:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = (size_reg == 2'd0) ? (lane_reg == 2'(gi))
                                                    : (lane_reg[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = !lane_en[gi]      ? old_reg[8*gi +: 8] :
                                       (size_reg == 2'd0) ? wdata_reg[7:0]
                                                          : wdata_reg[8*(gi%2) +: 8];
        end
    endgenerate

    assign byte_sel = bus.mem_dout[8*lane_reg +: 8];
    assign half_sel = bus.mem_dout[16*lane_reg[1] +: 16];

    always_comb begin
        state_next = state_reg;
        rdata_next = '0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end else if (bus.req_we) begin
                        state_next = bus.req_size[1] ? WR0 : RD0;
                    end else begin
                        state_next = RD0;
                    end
                end
            end
            RD0: begin
                if (we_reg) begin
                    state_next = MERGE;
                end else if (size_reg == 2'd3) begin
                    state_next = RD1;
                end else begin
                    state_next = RESP;
                    case (size_reg)
                        2'd0:    rdata_next = {{56{byte_sel[7] & ~uns_reg}}, byte_sel};
                        2'd1:    rdata_next = {{48{half_sel[15] & ~uns_reg}}, half_sel};
                        default: rdata_next = {{32{bus.mem_dout[31] & ~uns_reg}}, bus.mem_dout};
                    endcase
                end
            end
            RD1: begin
                state_next = RESP;
                rdata_next = {bus.mem_dout, old_reg};
            end
            WR0:     state_next = (size_reg == 2'd3) ? WR1 : RESP;
            WR1:     state_next = RESP;
            MERGE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_we_next  = 1'b0;
        mem_adr_next = '0;
        mem_din_next = '0;
        case (state_reg)
            RD0:     mem_adr_next = w0_reg;
            RD1:     mem_adr_next = w1;
            WR0: begin
                mem_we_next  = 1'b1;
                mem_adr_next = w0_reg;
                mem_din_next = wdata_reg[31:0];
            end
            WR1: begin
                mem_we_next  = 1'b1;
                mem_adr_next = w1;
                mem_din_next = wdata_reg[63:32];
            end
            MERGE: begin
                mem_we_next  = 1'b1;
                mem_adr_next = w0_reg;
                mem_din_next = merged;
            end
            default: ;
        endcase
        // A write in flight is suppressed by reset in the same cycle.
        if (rst) begin
            mem_we_next  = 1'b0;
            mem_din_next = '0;
        end
    end

    assign bus.mem_we     = mem_we_next;
    assign bus.mem_adr    = mem_adr_next;
    assign bus.mem_din    = mem_din_next;
    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= 2'd0;
            uns_reg        <= 1'b0;
            lane_reg       <= 2'd0;
            w0_reg         <= '0;
            wdata_reg      <= '0;
            old_reg        <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            resp_rdata_reg <= rdata_next;
            resp_err_reg   <= err_next;
            if (accept) begin
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                lane_reg  <= bus.req_addr[1:0];
                w0_reg    <= bus.req_addr[N+1:2];
                wdata_reg <= bus.req_wdata;
            end
            if (state_reg == RD0) begin
                old_reg <= bus.mem_dout;
            end
        end
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store initiator that drives the single-port, 32-bit-wide, word-addressed data RAM (write-enable, address, write data, combinational read data) from the RV64 core's memory stage. It converts byte-addressed B/H/W/D loads and stores into RAM word accesses. Sub-word stores use read-modify-write; doubleword accesses take two beats. Loads are sign- or zero-extended to 64 bits, and misaligned requests are rejected.

Parameters:
N, 20, RAM word-address width. RAM depth is 2^N words of 32 bits.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
req_unsigned  in  1  zero-extend the load (LBU/LHU/LWU)
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  misaligned request; valid with resp_valid
mem_we  out  1  RAM write enable
mem_adr  out  N  RAM word address
mem_din  out  32  RAM write data
mem_dout  in  32  RAM read data, combinational from mem_adr

Behaviour:
- Handshake: a request is accepted when req_valid && req_ready in IDLE. The request is registered in the accept cycle T, and inputs are ignored until the next IDLE.
- Address mapping: word address w0 = req_addr[N+1:2]. Upper address bits are ignored, so accesses wrap modulo RAM size. Byte lane = addr[1:0], little-endian.
- Alignment rule: the address is misaligned when (size H and addr[0]) or (size W and addr[1:0] != 0) or (size D and addr[2:0] != 0).
- Misaligned request: IDLE goes to RESP. At T+1: resp_valid = 1, resp_err = 1, resp_rdata = 0. mem_we is never asserted.
- FSM states: IDLE, RD0, RD1, WR0, WR1, MERGE, RESP.
- Load B/H/W: RD0 at T+1 drives mem_adr = w0 and captures mem_dout. RESP at T+2.
- Load D: RD0 at T+1 (w0, low half), RD1 at T+2 (w0+1, high half). RESP at T+3.
- Store W: WR0 at T+1 with mem_we = 1, mem_adr = w0, mem_din = wdata[31:0]. RESP at T+2.
- Store D: WR0 at T+1 writes wdata[31:0] to w0. WR1 at T+2 writes wdata[63:32] to w0+1. RESP at T+3.
- Store B/H: RD0 at T+1 captures the old word. MERGE at T+2 writes the old word with only the addressed byte/half lane replaced. RESP at T+3.
- Load extraction: byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - Sign-extend to 64 bits unless req_unsigned. req_unsigned is ignored for D.
- RESP state: resp_valid = 1 for exactly one cycle, resp_err = 0, then return to IDLE. resp_rdata and resp_err are registered and are 0 whenever resp_valid = 0.
- RAM-side outputs:
  - mem_we = 1 only in WR0, WR1 and MERGE, and is forced to 0 whenever rst = 1.
  - mem_adr is valid in RD0/RD1/WR0/WR1/MERGE and is 0 in IDLE and RESP.
  - mem_din is 0 when mem_we = 0.
- Throughput: req_ready is low from T+1 through the RESP cycle. The next acceptance is possible the cycle after RESP, so there is no overlap.
- Reset values: state IDLE; req_ready 0 while rst = 1, then 1 the cycle after rst deasserts. resp_valid, resp_err, resp_rdata, mem_we, mem_adr and mem_din are all 0.
- Reset mid-operation: the operation is aborted with no response.
  - Reset in WR1: word w0 stays written, w0+1 is not written.
  - Reset in MERGE: no write occurs.

Test Plan:
1. RAM word 0x10 = 0x80818283. LB at 0x43 -> resp at T+2, rdata 0xFFFFFFFFFFFFFF80. LBU at 0x43 -> 0x0000000000000080. LH at 0x42 -> 0xFFFFFFFFFFFF8081.
2. SH 0xBEEF at 0x42 over word 0x80818283 -> mem_we at T+2 only, word 0x10 = 0xBEEF8283, resp at T+3. SB 0x5A at 0x40 then gives 0xBEEF825A.
3. SD 0x1122334455667788 at 0x48 -> word 0x12 = 0x55667788, word 0x13 = 0x11223344, resp at T+3. LD at 0x48 -> rdata 0x1122334455667788 at T+3.
4. LW at 0x41 and SD at 0x44 -> resp_err = 1 at T+1, rdata = 0, mem_we never high, no RAM word changed.
5. req_valid held high for 3 back-to-back LW requests -> each accepted only in IDLE, req_ready low while busy, exactly 3 resp_valid pulses in order.
6. rst asserted in the WR1 cycle of an SD -> mem_we = 0 that cycle, no resp_valid, w0 updated and w0+1 unchanged, req_ready = 1 the cycle after rst drops.
